pattern_detector: RTL and testbench

Serial bit-stream sequence detector. Samples one input bit per clock and raises a single-cycle flag each time the most recent bits equal a fixed pattern, which is "101" by default. Overlapping matches are detected by default. It sits on a one-bit serial data path and feeds its match flag to downstream control or counting logic.

---
 rtl/pattern_detector_pkg.sv | 16 +
 rtl/pattern_detector.sv | 60 ++++++
 tb/tb_pattern_detector.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector.
package pattern_detector_pkg;

  localparam int unsigned DEFAULT_LEN = 3;
  localparam logic [DEFAULT_LEN-1:0] DEFAULT_PATTERN = 3'b101;

  // Equivalent Moore states of the default "101" detector, for waveform decoding.
  // StIdle: nothing useful seen, StGot1: "1", StGot10: "10", StMatch: "101" just seen.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGot1  = 2'd1,
    StGot10 = 2'd2,
    StMatch = 2'd3
  } pd_state_t;

endpackage

// File: rtl/pattern_detector.sv
// Serial bit-stream sequence detector with a registered single-cycle match flag.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int unsigned              PATTERN_LEN = DEFAULT_LEN,
  parameter logic [PATTERN_LEN-1:0]   PATTERN     = DEFAULT_PATTERN,
  parameter bit                       OVERLAP     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int unsigned     CntW    = $clog2(PATTERN_LEN + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(PATTERN_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(PATTERN_LEN - 1);

  if ((PATTERN_LEN < 2) || (PATTERN_LEN > 32)) begin : g_len_check
    $error("pattern_detector: PATTERN_LEN must be in 2..32");
  end

  logic [PATTERN_LEN-1:0] hist_q, hist_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   out_q, out_d;

  logic [PATTERN_LEN-1:0] shifted;
  logic                   match;

  // Next-state: shift in the new bit, gate the compare on enough valid bits having arrived.
  always_comb begin
    shifted = {hist_q[PATTERN_LEN-2:0], in};
    // cnt counts bits already held; the bit being sampled makes it one more.
    match   = (cnt_q >= CntLast) && (shifted == PATTERN);
    hist_d  = shifted;
    cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    out_d   = match;
    if (match && !OVERLAP) begin
      // Next match may only use bits received after this one.
      hist_d = '0;
      cnt_d  = '0;
    end
  end

  // State registers with synchronous reset that overrides the incoming bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed, table-driven bench for pattern_detector across four configurations.
module tb_pattern_detector;

  typedef struct {
    int    dut;    // 0: default, 1: no overlap, 2: len 4 "1101", 3: "001"
    bit    rst;
    bit    in;
    bit    exp;    // out expected right after this edge
    string name;
  } vec_t;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] in_v;
  logic [3:0] out_v;

  int tests_run;
  int tests_failed;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pattern_detector u_dflt (
    .clk (clk),
    .rst (rst_v[0]),
    .in  (in_v[0]),
    .out (out_v[0])
  );

  pattern_detector #(
    .PATTERN_LEN (3),
    .PATTERN     (3'b101),
    .OVERLAP     (1'b0)
  ) u_novl (
    .clk (clk),
    .rst (rst_v[1]),
    .in  (in_v[1]),
    .out (out_v[1])
  );

  pattern_detector #(
    .PATTERN_LEN (4),
    .PATTERN     (4'b1101),
    .OVERLAP     (1'b1)
  ) u_len4 (
    .clk (clk),
    .rst (rst_v[2]),
    .in  (in_v[2]),
    .out (out_v[2])
  );

  pattern_detector #(
    .PATTERN_LEN (3),
    .PATTERN     (3'b001),
    .OVERLAP     (1'b1)
  ) u_p001 (
    .clk (clk),
    .rst (rst_v[3]),
    .in  (in_v[3]),
    .out (out_v[3])
  );

  task automatic add(input int dut, input bit rst, input bit in, input bit exp,
                     input string name);
    vec_t v;
    v.dut  = dut;
    v.rst  = rst;
    v.in   = in;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one bit on the falling edge, check out just after the rising edge.
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    rst_v[v.dut] = v.rst;
    in_v[v.dut]  = v.in;
    @(posedge clk);
    #1;
    rst_v[v.dut] = 1'b0;
    tests_run++;
    if (out_v[v.dut] !== v.exp) begin
      tests_failed++;
      $display("FAIL %s vec %0d (dut %0d): out=%b expected %b", v.name, idx, v.dut,
               out_v[v.dut], v.exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_v        = 4'b0000;
    in_v         = 4'b0000;

    // Default "101", overlapping: reset then basic match, then reset clears out.
    add(0, 1, 0, 0, "dflt_reset");
    add(0, 0, 0, 0, "dflt_basic");
    add(0, 0, 1, 0, "dflt_basic");
    add(0, 0, 0, 0, "dflt_basic");
    add(0, 0, 1, 1, "dflt_basic");
    add(0, 1, 1, 0, "dflt_reset_clears_out");
    // Overlap run: pulses after bits 4, 7, 9, 15.
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 1, 0, "dflt_ovl");
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 1, 1, "dflt_ovl");
    add(0, 0, 1, 0, "dflt_ovl");
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 1, 1, "dflt_ovl");
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 1, 1, "dflt_ovl");
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 1, 0, "dflt_ovl");
    add(0, 0, 0, 0, "dflt_ovl");
    add(0, 0, 1, 1, "dflt_ovl");
    // Near-misses never match.
    add(0, 1, 0, 0, "dflt_near_reset");
    add(0, 0, 1, 0, "dflt_near");
    add(0, 0, 1, 0, "dflt_near");
    add(0, 0, 0, 0, "dflt_near");
    add(0, 0, 0, 0, "dflt_near");
    add(0, 0, 1, 0, "dflt_near");
    add(0, 0, 0, 0, "dflt_near");
    add(0, 0, 0, 0, "dflt_near");
    // Reset mid-pattern (with in=1 on the reset edge) discards the partial match.
    add(0, 1, 0, 0, "dflt_mid_reset");
    add(0, 0, 1, 0, "dflt_mid");
    add(0, 0, 0, 0, "dflt_mid");
    add(0, 1, 1, 0, "dflt_mid_rst_edge");
    add(0, 0, 1, 0, "dflt_mid_after");
    add(0, 0, 0, 0, "dflt_mid_after");
    add(0, 0, 1, 1, "dflt_mid_after");

    // Non-overlapping "101": only bit 3 matches in 1,0,1,0,1; then 0,1 completes a fresh one.
    add(1, 1, 0, 0, "novl_reset");
    add(1, 0, 1, 0, "novl");
    add(1, 0, 0, 0, "novl");
    add(1, 0, 1, 1, "novl");
    add(1, 0, 0, 0, "novl");
    add(1, 0, 1, 0, "novl_no_share");
    add(1, 0, 0, 0, "novl");
    add(1, 0, 1, 1, "novl_fresh");

    // Length 4 "1101": pulses after bits 4 and 7.
    add(2, 1, 0, 0, "len4_reset");
    add(2, 0, 1, 0, "len4");
    add(2, 0, 1, 0, "len4");
    add(2, 0, 0, 0, "len4");
    add(2, 0, 1, 1, "len4");
    add(2, 0, 1, 0, "len4");
    add(2, 0, 0, 0, "len4");
    add(2, 0, 1, 1, "len4");

    // "001": cleared history must not pass for leading zeros before 3 bits arrive.
    add(3, 1, 0, 0, "p001_reset");
    add(3, 0, 1, 0, "p001_first_bit");
    add(3, 0, 0, 0, "p001");
    add(3, 0, 0, 0, "p001");
    add(3, 0, 1, 1, "p001_match");
    add(3, 1, 0, 0, "p001_reset2");
    add(3, 0, 0, 0, "p001_two_bits");
    add(3, 0, 1, 0, "p001_two_bits");
    add(3, 0, 1, 0, "p001");
    add(3, 1, 0, 0, "p001_reset3");
    add(3, 0, 0, 0, "p001");
    add(3, 0, 0, 0, "p001");
    add(3, 0, 1, 1, "p001_match2");

    foreach (vecs[i]) step(vecs[i], i);

    // Hand sequence: all DUTs reset together, then a long zero run keeps every flag low.
    @(negedge clk);
    rst_v = 4'b1111;
    in_v  = 4'b1111;
    @(posedge clk);
    #1;
    rst_v = 4'b0000;
    tests_run++;
    if (out_v !== 4'b0000) begin
      tests_failed++;
      $display("FAIL joint_reset: out=%b expected %b", out_v, 4'b0000);
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      in_v = 4'b0000;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_v !== 4'b0000) begin
        tests_failed++;
        $display("FAIL zero_run cycle %0d: out=%b expected %b", n, out_v, 4'b0000);
      end
    end

    // Hand sequence: default DUT on "10101" gives pulses exactly two cycles apart.
    begin
      bit [4:0] bits;
      bit [4:0] exp;
      bits = 5'b10101;
      exp  = 5'b00101;
      for (int n = 4; n >= 0; n--) begin
        @(negedge clk);
        in_v[0] = bits[n];
        @(posedge clk);
        #1;
        tests_run++;
        if (out_v[0] !== exp[n]) begin
          tests_failed++;
          $display("FAIL dflt_10101 bit %0d: out=%b expected %b", 4 - n, out_v[0], exp[n]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
